// File: rtl/simo_multipath_splitter.sv
// Single-input, two-output multipath source: a direct path plus a delayed,
// shift-attenuated echo drawn from a small history RAM that is zeroed on every config load.
module simo_multipath_splitter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_DELAY = 16,
   parameter int unsigned DLY_W     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_load,
   input  logic [DLY_W-1:0] delay_cfg,
   input  logic [2:0]       atten_cfg,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_sample,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] pathone,
   output logic [WIDTH-1:0] pathtwo,
   output logic             busy
);

   localparam logic [0:0] ST_FLUSH = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;
   localparam logic [DLY_W-1:0] CNT_LAST = DLY_W'(MAX_DELAY - 1);

   logic [0:0]       state_q, state_d;
   logic [DLY_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [DLY_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [DLY_W-1:0] delay_q, delay_d;
   logic [2:0]       atten_q, atten_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] pathone_q, pathone_d;
   logic [WIDTH-1:0] pathtwo_q, pathtwo_d;

   logic [WIDTH-1:0] hist_q [MAX_DELAY];
   logic             hist_we;
   logic [DLY_W-1:0] hist_waddr;
   logic [WIDTH-1:0] hist_wdata;

   logic                    in_ready_c;
   logic                    accept;
   logic [DLY_W-1:0]        rd_addr;
   logic signed [WIDTH-1:0] echo_s;

   // Next-state, history write port and output datapath
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      wr_ptr_d    = wr_ptr_q;
      delay_d     = delay_q;
      atten_d     = atten_q;
      out_valid_d = out_valid_q;
      pathone_d   = pathone_q;
      pathtwo_d   = pathtwo_q;
      hist_we     = 1'b0;
      hist_waddr  = wr_ptr_q;
      hist_wdata  = in_sample;

      in_ready_c = (state_q == ST_RUN) && !cfg_load && (!out_valid_q || out_ready);
      accept     = in_valid && in_ready_c;
      rd_addr    = wr_ptr_q - delay_q;
      echo_s     = (delay_q == '0) ? in_sample : hist_q[rd_addr];

      if (cfg_load) begin
         delay_d     = delay_cfg;
         atten_d     = atten_cfg;
         flush_cnt_d = '0;
         state_d     = ST_FLUSH;
      end else if (state_q == ST_FLUSH) begin
         hist_we     = 1'b1;
         hist_waddr  = flush_cnt_q;
         hist_wdata  = '0;
         flush_cnt_d = flush_cnt_q + DLY_W'(1);
         if (flush_cnt_q == CNT_LAST) begin
            state_d  = ST_RUN;
            wr_ptr_d = '0;
         end
      end else if (accept) begin
         hist_we  = 1'b1;
         wr_ptr_d = wr_ptr_q + DLY_W'(1);
      end

      // A pending output survives cfg_load; only a consume or a new accept changes it
      if (accept) begin
         out_valid_d = 1'b1;
         pathone_d   = in_sample;
         pathtwo_d   = echo_s >>> atten_q;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_FLUSH;
         flush_cnt_q <= '0;
         wr_ptr_q    <= '0;
         delay_q     <= '0;
         atten_q     <= '0;
         out_valid_q <= 1'b0;
         pathone_q   <= '0;
         pathtwo_q   <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         delay_q     <= delay_d;
         atten_q     <= atten_d;
         out_valid_q <= out_valid_d;
         pathone_q   <= pathone_d;
         pathtwo_q   <= pathtwo_d;
      end
   end

   // History RAM has no reset; the flush sequence clears it
   always_ff @(posedge clk) begin
      if (hist_we) begin
         hist_q[hist_waddr] <= hist_wdata;
      end
   end

   assign in_ready  = in_ready_c;
   assign out_valid = out_valid_q;
   assign pathone   = pathone_q;
   assign pathtwo   = pathtwo_q;
   assign busy      = (state_q == ST_FLUSH);

endmodule
